led_bus_master: RTL and testbench
=================================

Name: led_bus_master

Overview:
- Initiator end of the LED controller register bus: converts queued read/write commands into bus_if cycles toward led_controller.
- Commands enter through a valid/ready request port into a small FIFO.
- Each command executes as setup → strobe → turnaround on clk_400K; read data returns on a response port.
- Sits between the host-side sequencer (I2C slave front end / test sequencer) and led_controller; replaces hand-driven bus stimulus.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, ≥2)
ADDR_BITS, 4, register address width (matches reg_enum_t width)
DATA_BITS, 8, data width (from led_driver_pkg)

Ports:
clk_400K  input  1  400 kHz bus clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
req_valid  input  1  command offered
req_ready  output  1  FIFO not full; handshake when req_valid && req_ready at clock edge
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_BITS  target register (reg_enum_t)
req_wdata  input  DATA_BITS  write data (ignored for reads)
rsp_valid  output  1  one-cycle pulse: read data valid
rsp_addr  output  ADDR_BITS  address of returned read
rsp_rdata  output  DATA_BITS  captured read data
busy  output  1  FIFO non-empty or FSM not IDLE
bus_addr  output  ADDR_BITS  bus_if.addr
bus_data  inout  DATA_BITS  bus_if.data, driven only while bus_w_en=1, else 'z
bus_w_en  output  1  bus_if.w_en
bus_r_en  output  1  bus_if.r_en

Behaviour:
- Reset (async, immediate): bus_w_en=0, bus_r_en=0, bus_addr=0, bus_data='z, rsp_valid=0, rsp_addr=0, rsp_rdata=0, FIFO emptied, FSM=IDLE, req_ready=1, busy=0.
- FIFO:
  - Push on handshake; pop when FSM leaves IDLE with the head command.
  - req_ready = !full, registered from pointer state.
  - When full, no push occurs even if req_valid is high.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
- FSM states: IDLE, SETUP, STROBE, TURN.
  - IDLE: if FIFO non-empty, pop head, latch cmd → SETUP. Else stay.
  - SETUP (1 cycle): bus_addr=cmd.addr; enables 0 → STROBE.
  - STROBE (1 cycle): bus_addr held.
    - Write: bus_w_en=1, bus_data=cmd.wdata.
    - Read: bus_r_en=1, bus_data='z; bus_data sampled into rsp_rdata at the rising edge ending STROBE.
    - → TURN.
  - TURN (1 cycle): enables 0, bus_data='z, bus_addr held.
    - Read: rsp_valid=1 with rsp_addr=cmd.addr.
    - → IDLE.
- bus_w_en and bus_r_en are never both 1. Each enable is high for exactly one clock per command.
- Latency: command pushed at edge N into an empty FIFO with FSM IDLE:
  - popped at N+1
  - SETUP during N+1..N+2
  - STROBE N+2..N+3
  - TURN (rsp_valid) N+3..N+4
- Throughput: one command per 4 cycles (IDLE visit included). Back-to-back commands always have ≥2 cycles with both enables low between strobes.
- rsp_valid has no backpressure; the consumer must accept it. rsp_rdata/rsp_addr hold until the next read completes.
- Commands execute strictly in FIFO order; reads and writes are never reordered.
- Reset mid-transaction: the in-flight command is discarded and no rsp_valid is produced. bus_w_en/bus_r_en drop in the same instant reset asserts.
- All outputs are registered; bus_data output-enable = bus_w_en register.

Decomposition:
- led_driver_pkg (existing): DATA_BITS, reg_enum_t.
- Added to led_driver_pkg:
  - ADDR_BITS
  - typedef enum bus_state_t {IDLE, SETUP, STROBE, TURN}
  - typedef struct packed bus_cmd_t {write, addr, wdata}
- Sub-module bus_cmd_fifo: parameterised FIFO_DEPTH synchronous FIFO of bus_cmd_t with full/empty. Async reset clears the pointers.

Test Plan:
- Single write REG_PWM0=8'h40 to idle master → SETUP addr=REG_PWM0 at N+1; bus_w_en=1 with bus_data=8'h40 for exactly one cycle at N+2; led_controller PWM0 reads back 8'h40.
- Write REG_GRPPWM=8'hC0 then read REG_GRPPWM → bus_r_en one cycle; rsp_valid single pulse, rsp_addr=REG_GRPPWM, rsp_rdata=8'hC0; bus_data 'z outside the write strobe.
- Hold req_valid high with writes PWM0..PWM3=8'h40,8'h80,8'hC0,8'hFF plus LEDOUT=8'hAA, FIFO_DEPTH=4 → req_ready low while 4 queued; all 5 strobes appear in order, 4 cycles apart; never w_en && r_en.
- Push while popping at full-1 occupancy → count stays constant; no command lost or duplicated (scoreboard order check).
- Assert reset during STROBE of a read of REG_PWM1 → enables 0 immediately; no rsp_valid; FIFO empty; busy=0; req_ready=1.
- After a reset of led_controller, read PWM0..PWM3 → rsp_rdata = reset values (8'h00) for each, four rsp_valid pulses.

Source files
------------

// File: rtl/led_bus_master_pkg.sv
// Shared types for the LED controller register bus initiator: register map,
// bus sequencer states and the queued command format.
package led_bus_master_pkg;

   localparam int DATA_BITS = 8;
   localparam int ADDR_BITS = 4;

   typedef enum logic [ADDR_BITS-1:0] {
      REG_MODE1   = 4'h0,
      REG_MODE2   = 4'h1,
      REG_PWM0    = 4'h2,
      REG_PWM1    = 4'h3,
      REG_PWM2    = 4'h4,
      REG_PWM3    = 4'h5,
      REG_GRPPWM  = 4'h6,
      REG_GRPFREQ = 4'h7,
      REG_LEDOUT  = 4'h8
   } reg_enum_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      TURN   = 2'd3
   } bus_state_t;

   typedef struct packed {
      logic                 write;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] wdata;
   } bus_cmd_t;

endpackage

// File: rtl/led_bus_master_fifo.sv
// Command queue for led_bus_master: synchronous FIFO of bus_cmd_t with an
// extra pointer bit to tell full from empty. Reset clears only the pointers.
module bus_cmd_fifo
   import led_bus_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  bus_cmd_t push_cmd,
   input  logic     pop,
   output bus_cmd_t head_cmd,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   bus_cmd_t       mem [FIFO_DEPTH];

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head_cmd = mem[rd_ptr[PTR_W-1:0]];

   // Pointer advance; a push is refused while full, a pop while empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[PTR_W-1:0]] <= push_cmd;
   end

endmodule

// File: rtl/led_bus_master.sv
// Register bus initiator toward led_controller: queues host commands and
// plays each one out as setup -> strobe -> turnaround, returning read data.
module led_bus_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_BITS  = led_bus_master_pkg::ADDR_BITS,
   parameter int DATA_BITS  = led_bus_master_pkg::DATA_BITS
) (
   input  logic                 clk_400K,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [DATA_BITS-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [ADDR_BITS-1:0] rsp_addr,
   output logic [DATA_BITS-1:0] rsp_rdata,
   output logic                 busy,
   output logic [ADDR_BITS-1:0] bus_addr,
   inout  wire  [DATA_BITS-1:0] bus_data,
   output logic                 bus_w_en,
   output logic                 bus_r_en
);

   import led_bus_master_pkg::*;

   bus_state_t           state;
   bus_cmd_t             push_cmd;
   bus_cmd_t             head_cmd;
   bus_cmd_t             cmd_q;
   logic [DATA_BITS-1:0] bus_wdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_push;
   logic                 fifo_pop;

   assign push_cmd.write = req_write;
   assign push_cmd.addr  = req_addr;
   assign push_cmd.wdata = req_wdata;

   assign fifo_push = req_valid && !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;

   assign req_ready = !fifo_full;
   assign busy      = !fifo_empty || (state != IDLE);

   // Data lines are driven only while the write strobe register is set.
   assign bus_data  = bus_w_en ? bus_wdata : {DATA_BITS{1'bz}};

   bus_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_400K),
      .reset    (reset),
      .push     (fifo_push),
      .push_cmd (push_cmd),
      .pop      (fifo_pop),
      .head_cmd (head_cmd),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Bus sequencer: every bus-facing control output is registered here.
   always_ff @(posedge clk_400K or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bus_addr  <= '0;
         bus_w_en  <= 1'b0;
         bus_r_en  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  bus_addr <= head_cmd.addr;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               bus_w_en <= cmd_q.write;
               bus_r_en <= !cmd_q.write;
               state    <= STROBE;
            end
            STROBE: begin
               bus_w_en <= 1'b0;
               bus_r_en <= 1'b0;
               if (!cmd_q.write) begin
                  rsp_rdata <= bus_data;
                  rsp_addr  <= cmd_q.addr;
                  rsp_valid <= 1'b1;
               end
               state <= TURN;
            end
            TURN: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Command and write-data holding registers; no reset needed on data.
   always_ff @(posedge clk_400K) begin
      if (fifo_pop)
         cmd_q <= head_cmd;
      if (state == SETUP)
         bus_wdata <= cmd_q.wdata;
   end

endmodule

// File: tb/tb_led_bus_master.sv
// Bench for led_bus_master: a register-file slave stands in for
// led_controller; strobes and read responses are scoreboarded.
module tb_led_bus_master;

   import led_bus_master_pkg::*;

   typedef struct {
      logic       write;
      logic [3:0] addr;
      logic [7:0] data;
      int         gap;
   } strobe_t;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } rsp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [3:0] rsp_addr;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic [3:0] bus_addr;
   wire  [7:0] bus_data;
   logic       bus_w_en;
   logic       bus_r_en;

   logic [7:0] slv_regs [16];
   logic       slv_rst;

   strobe_t    sq[$];
   rsp_t       rq[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         last_cyc = 0;
   logic       last_ok = 1'b0;

   always #5 clk = ~clk;

   led_bus_master #(
      .FIFO_DEPTH (4),
      .ADDR_BITS  (4),
      .DATA_BITS  (8)
   ) dut (
      .clk_400K  (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_addr  (rsp_addr),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .bus_w_en  (bus_w_en),
      .bus_r_en  (bus_r_en)
   );

   // Register-file slave: drives read data during the read strobe.
   assign bus_data = bus_r_en ? slv_regs[bus_addr] : 8'hzz;

   always @(posedge clk) begin
      if (slv_rst) begin
         for (int i = 0; i < 16; i++) slv_regs[i] <= 8'h00;
      end else if (bus_w_en) begin
         slv_regs[bus_addr] <= bus_data;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes or responds.
   always @(negedge clk) begin
      strobe_t e;
      rsp_t    r;
      if (reset) begin
         last_ok = 1'b0;
      end else begin
         check("enables_exclusive", {31'b0, bus_w_en && bus_r_en}, 32'd0);
         if (bus_w_en || bus_r_en) begin
            if (sq.size() == 0) begin
               check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = sq.pop_front();
               check("strobe_write", {31'b0, bus_w_en}, {31'b0, e.write});
               check("strobe_addr", {28'b0, bus_addr}, {28'b0, e.addr});
               if (e.write)
                  check("strobe_wdata", {24'b0, bus_data}, {24'b0, e.data});
               if (e.gap != 0 && last_ok)
                  check("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
            last_ok  = 1'b1;
         end
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               r = rq.pop_front();
               check("rsp_addr", {28'b0, rsp_addr}, {28'b0, r.addr});
               check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, r.data});
            end
         end
      end
   end

   task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input int gap, input logic exp_rsp, input logic [7:0] rexp);
      int waitc;
      waitc = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready) begin
         @(negedge clk);
         waitc++;
         if (waitc > 50) begin
            check("push_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
         end
      end
      sq.push_back('{w, a, d, gap});
      if (!w && exp_rsp) rq.push_back('{a, rexp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || sq.size() != 0 || rq.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", {31'b0, n >= 200}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      slv_rst   = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_w_en", {31'b0, bus_w_en}, 32'd0);
      check("rst_r_en", {31'b0, bus_r_en}, 32'd0);
      check("rst_bus_addr", {28'b0, bus_addr}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_addr", {28'b0, rsp_addr}, 32'd0);
      check("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      reset   = 1'b0;
      slv_rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single write with cycle-exact phase checks
      push(1'b1, REG_PWM0, 8'h40, 0, 1'b0, 8'h00);
      idle();
      @(negedge clk);
      check("t1_setup_addr", {28'b0, bus_addr}, {28'b0, REG_PWM0});
      check("t1_setup_w_en", {31'b0, bus_w_en}, 32'd0);
      check("t1_setup_r_en", {31'b0, bus_r_en}, 32'd0);
      @(negedge clk);
      check("t1_strobe_w_en", {31'b0, bus_w_en}, 32'd1);
      check("t1_strobe_data", {24'b0, bus_data}, 32'h40);
      @(negedge clk);
      check("t1_turn_w_en", {31'b0, bus_w_en}, 32'd0);
      check("t1_turn_addr", {28'b0, bus_addr}, {28'b0, REG_PWM0});
      check("t1_turn_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      wait_idle();
      check("t1_slave_pwm0", {24'b0, slv_regs[REG_PWM0]}, 32'h40);

      // Write then read back GRPPWM
      push(1'b1, REG_GRPPWM, 8'hC0, 0, 1'b0, 8'h00);
      push(1'b0, REG_GRPPWM, 8'h00, 4, 1'b1, 8'hC0);
      idle();
      wait_idle();

      // Burst of five writes held back-to-back; FIFO fills
      push(1'b1, REG_PWM0,   8'h40, 0, 1'b0, 8'h00);
      push(1'b1, REG_PWM1,   8'h80, 4, 1'b0, 8'h00);
      push(1'b1, REG_PWM2,   8'hC0, 4, 1'b0, 8'h00);
      push(1'b1, REG_PWM3,   8'hFF, 4, 1'b0, 8'h00);
      push(1'b1, REG_LEDOUT, 8'hAA, 4, 1'b0, 8'h00);
      check("t3_full_ready", {31'b0, req_ready}, 32'd0);
      check("t3_full_busy", {31'b0, busy}, 32'd1);
      idle();
      wait_idle();
      check("t3_slave_pwm3", {24'b0, slv_regs[REG_PWM3]}, 32'hFF);
      check("t3_slave_ledout", {24'b0, slv_regs[REG_LEDOUT]}, 32'hAA);

      // Push coinciding with pop at occupancy 3
      push(1'b0, REG_PWM0,  8'h00, 0, 1'b1, 8'h40);
      push(1'b1, REG_MODE1, 8'h01, 4, 1'b0, 8'h00);
      push(1'b0, REG_PWM3,  8'h00, 4, 1'b1, 8'hFF);
      push(1'b1, REG_MODE2, 8'h05, 4, 1'b0, 8'h00);
      idle();
      push(1'b0, REG_MODE1, 8'h00, 4, 1'b1, 8'h01);
      check("t4_ready_after_pushpop", {31'b0, req_ready}, 32'd1);
      idle();
      wait_idle();

      // Reset during a read strobe
      push(1'b0, REG_PWM1, 8'h00, 0, 1'b0, 8'h00);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("t5_strobe_r_en", {31'b0, bus_r_en}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("t5_rst_r_en", {31'b0, bus_r_en}, 32'd0);
      check("t5_rst_w_en", {31'b0, bus_w_en}, 32'd0);
      check("t5_rst_busy", {31'b0, busy}, 32'd0);
      check("t5_rst_ready", {31'b0, req_ready}, 32'd1);
      check("t5_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("t5_post_busy", {31'b0, busy}, 32'd0);

      // Slave reset, then read PWM0..PWM3
      @(negedge clk);
      slv_rst = 1'b1;
      @(negedge clk);
      slv_rst = 1'b0;
      push(1'b0, REG_PWM0, 8'h00, 0, 1'b1, 8'h00);
      push(1'b0, REG_PWM1, 8'h00, 4, 1'b1, 8'h00);
      push(1'b0, REG_PWM2, 8'h00, 4, 1'b1, 8'h00);
      push(1'b0, REG_PWM3, 8'h00, 4, 1'b1, 8'h00);
      idle();
      wait_idle();

      check("end_strobe_queue", sq.size(), 32'd0);
      check("end_rsp_queue", rq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
